tx_frame_buffer: RTL and testbench

TX_FRAME_BUFFER -- requirements
Module: tx_frame_buffer

---
 rtl/uart_pkg.sv | 13 +
 rtl/buffer_mem.sv | 25 ++
 rtl/tx_frame_buffer.sv | 113 +++++++++++
 tb/tb_tx_frame_buffer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: buffer operating modes and
// the frame-buffer state encoding.
package uart_pkg;

    localparam int MODE_FRAME  = 0;
    localparam int MODE_STREAM = 1;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/buffer_mem.sv
// DEPTH x DATA_W storage array: synchronous write, asynchronous read.
module buffer_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: rtl/tx_frame_buffer.sv
// Transmit buffer feeding the UART: frame mode (fill all, then drain all) or
// plain stream FIFO, with sticky overflow/underflow flags.
module tx_frame_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int MODE   = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr,
    input  logic [DATA_W-1:0]          w_data,
    input  logic                       rd,
    input  logic                       flush,
    input  logic                       clr_err,
    output logic [DATA_W-1:0]          r_data,
    output logic                       avail,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    import uart_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    state_t            state;
    logic [DATA_W-1:0] mem_data;

    logic is_full, is_empty;
    logic can_pop, can_wr, rd_reject;
    logic wr_ok, rd_ok, ovf_set, udf_set;

    assign is_full  = (cnt == CNT_W'(DEPTH));
    assign is_empty = (cnt == '0);

    always_comb begin
        can_pop   = 1'b0;
        can_wr    = 1'b0;
        rd_reject = 1'b0;
        if (MODE == MODE_FRAME) begin
            can_pop = (state == DRAIN);
            can_wr  = (state == FILL);
        end else begin
            // A pop in the same cycle frees the slot the write lands in.
            can_pop   = !is_empty;
            can_wr    = !is_full || (rd && can_pop);
            rd_reject = rd && is_empty;
        end
        wr_ok   = wr && can_wr && !flush;
        rd_ok   = rd && can_pop && !flush;
        ovf_set = wr && !can_wr && !flush;
        udf_set = rd_reject && !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            state     <= FILL;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_set || (overflow && !clr_err);
            underflow <= udf_set || (underflow && !clr_err);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                state  <= FILL;
            end else begin
                if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
                if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
                if (wr_ok && !rd_ok) cnt <= cnt + CNT_W'(1);
                else if (!wr_ok && rd_ok) cnt <= cnt - CNT_W'(1);
                if (MODE == MODE_FRAME) begin
                    if (state == FILL && wr_ok && cnt == CNT_W'(DEPTH - 1)) begin
                        state <= DRAIN;
                    end else if (state == DRAIN && rd_ok && cnt == CNT_W'(1)) begin
                        state  <= FILL;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                    end
                end
            end
        end
    end

    buffer_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk    (clk),
        .we     (wr_ok),
        .w_addr (wr_ptr),
        .w_data (w_data),
        .r_addr (rd_ptr),
        .r_data (mem_data)
    );

    assign avail  = can_pop;
    assign r_data = avail ? mem_data : '0;
    assign full   = is_full;
    assign empty  = is_empty;
    assign count  = cnt;

endmodule

// File: tb/tb_tx_frame_buffer.sv
// Bench for tx_frame_buffer: one frame-mode and one stream-mode instance,
// directed scenarios plus randomized traffic against a queue model.
module tb_tx_frame_buffer;

    localparam int DW = 8;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          m0_wr = 0, m0_rd = 0, m0_flush = 0, m0_clr = 0;
    logic [DW-1:0] m0_wdata = '0;
    logic [DW-1:0] m0_rdata;
    logic          m0_avail, m0_full, m0_empty, m0_ovf, m0_udf;
    logic [2:0]    m0_count;

    logic          m1_wr = 0, m1_rd = 0, m1_flush = 0, m1_clr = 0;
    logic [DW-1:0] m1_wdata = '0;
    logic [DW-1:0] m1_rdata;
    logic          m1_avail, m1_full, m1_empty, m1_ovf, m1_udf;
    logic [2:0]    m1_count;

    int vectors = 0;
    int miscompares = 0;

    tx_frame_buffer #(.DATA_W(DW), .DEPTH(D), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr(m0_wr), .w_data(m0_wdata), .rd(m0_rd),
        .flush(m0_flush), .clr_err(m0_clr), .r_data(m0_rdata), .avail(m0_avail),
        .full(m0_full), .empty(m0_empty), .count(m0_count),
        .overflow(m0_ovf), .underflow(m0_udf)
    );

    tx_frame_buffer #(.DATA_W(DW), .DEPTH(D), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr(m1_wr), .w_data(m1_wdata), .rd(m1_rd),
        .flush(m1_flush), .clr_err(m1_clr), .r_data(m1_rdata), .avail(m1_avail),
        .full(m1_full), .empty(m1_empty), .count(m1_count),
        .overflow(m1_ovf), .underflow(m1_udf)
    );

    // Packed view: {count, full, empty, avail, overflow, underflow, r_data}
    function automatic logic [15:0] pack(input logic [2:0] c, input logic f, input logic e,
                                         input logic a, input logic o, input logic u,
                                         input logic [7:0] d);
        return {c, f, e, a, o, u, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m0_write(input logic [7:0] v);
        m0_wr = 1; m0_wdata = v; tick(); m0_wr = 0;
    endtask

    task automatic m1_write(input logic [7:0] v);
        m1_wr = 1; m1_wdata = v; tick(); m1_wr = 0;
    endtask

    task automatic test_reset();
        logic [15:0] exp, act;
        #3;
        exp = pack(3'd0, 0, 1, 0, 0, 0, 8'h00);
        act = pack(m0_count, m0_full, m0_empty, m0_avail, m0_ovf, m0_udf, m0_rdata);
        vectors++;
        if (act !== exp) begin miscompares++; $display("FAIL reset_m0 got=%h exp=%h", act, exp); end
        act = pack(m1_count, m1_full, m1_empty, m1_avail, m1_ovf, m1_udf, m1_rdata);
        vectors++;
        if (act !== exp) begin miscompares++; $display("FAIL reset_m1 got=%h exp=%h", act, exp); end
        @(posedge clk); #1; rst_n = 1;
        tick();
    endtask

    task automatic test_frame_fill_drain();
        logic [7:0] vals [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (m0_avail !== 1'b0) begin miscompares++; $display("FAIL frame_fill_avail[%0d] got=%b exp=0", i, m0_avail); end
            m0_write(vals[i]);
        end
        vectors++;
        if ({m0_avail, m0_full, m0_count} !== {1'b1, 1'b1, 3'd4}) begin
            miscompares++; $display("FAIL frame_ready got=%b%b%0d exp=114", m0_avail, m0_full, m0_count);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (m0_rdata !== vals[i]) begin miscompares++; $display("FAIL frame_pop[%0d] got=%h exp=%h", i, m0_rdata, vals[i]); end
            m0_rd = 1; tick(); m0_rd = 0;
        end
        vectors++;
        if ({m0_avail, m0_empty, m0_rdata} !== {1'b0, 1'b1, 8'h00}) begin
            miscompares++; $display("FAIL frame_drained got avail=%b empty=%b r_data=%h exp 0,1,00", m0_avail, m0_empty, m0_rdata);
        end
    endtask

    task automatic test_frame_misuse();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        m0_write(vals[0]);
        m0_rd = 1; tick(); m0_rd = 0;
        vectors++;
        if ({m0_count, m0_udf, m0_avail} !== {3'd1, 1'b0, 1'b0}) begin
            miscompares++; $display("FAIL fill_rd_ignored got count=%0d udf=%b avail=%b exp 1,0,0", m0_count, m0_udf, m0_avail);
        end
        for (int i = 1; i < 4; i++) m0_write(vals[i]);
        m0_write(8'h99);
        vectors++;
        if ({m0_ovf, m0_count, m0_rdata} !== {1'b1, 3'd4, 8'h11}) begin
            miscompares++; $display("FAIL drain_overflow got ovf=%b count=%0d r_data=%h exp 1,4,11", m0_ovf, m0_count, m0_rdata);
        end
        m0_clr = 1; tick(); m0_clr = 0;
        vectors++;
        if (m0_ovf !== 1'b0) begin miscompares++; $display("FAIL clr_err got=%b exp=0", m0_ovf); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (m0_rdata !== vals[i]) begin miscompares++; $display("FAIL misuse_pop[%0d] got=%h exp=%h", i, m0_rdata, vals[i]); end
            m0_rd = 1; tick(); m0_rd = 0;
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) m0_write(8'hE0 + 8'(i));
        for (int i = 0; i < 2; i++) begin m0_rd = 1; tick(); m0_rd = 0; end
        m0_flush = 1; m0_wr = 1; m0_wdata = 8'h77; tick(); m0_flush = 0; m0_wr = 0;
        vectors++;
        if (pack(m0_count, m0_full, m0_empty, m0_avail, m0_ovf, m0_udf, m0_rdata) !== pack(3'd0, 0, 1, 0, 0, 0, 8'h00)) begin
            miscompares++;
            $display("FAIL flush_mid_drain got count=%0d avail=%b ovf=%b empty=%b exp 0,0,0,1", m0_count, m0_avail, m0_ovf, m0_empty);
        end
        m0_write(8'h5C);
        vectors++;
        if ({m0_count, m0_avail} !== {3'd1, 1'b0}) begin
            miscompares++; $display("FAIL flush_then_fill got count=%0d avail=%b exp 1,0", m0_count, m0_avail);
        end
        m0_flush = 1; tick(); m0_flush = 0;
    endtask

    task automatic test_stream_boundaries();
        logic [7:0] exp_seq [4] = '{8'h20, 8'h30, 8'h40, 8'h55};
        m1_write(8'h10); m1_write(8'h20); m1_write(8'h30); m1_write(8'h40);
        vectors++;
        if ({m1_full, m1_count} !== {1'b1, 3'd4}) begin
            miscompares++; $display("FAIL stream_full got full=%b count=%0d exp 1,4", m1_full, m1_count);
        end
        m1_wr = 1; m1_wdata = 8'h55; m1_rd = 1; tick(); m1_wr = 0; m1_rd = 0;
        vectors++;
        if ({m1_count, m1_ovf, m1_rdata} !== {3'd4, 1'b0, 8'h20}) begin
            miscompares++; $display("FAIL full_wr_rd got count=%0d ovf=%b r_data=%h exp 4,0,20", m1_count, m1_ovf, m1_rdata);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (m1_rdata !== exp_seq[i]) begin miscompares++; $display("FAIL stream_pop[%0d] got=%h exp=%h", i, m1_rdata, exp_seq[i]); end
            m1_rd = 1; tick(); m1_rd = 0;
        end
        m1_rd = 1; tick(); m1_rd = 0;
        vectors++;
        if ({m1_udf, m1_avail, m1_empty} !== 3'b101) begin
            miscompares++; $display("FAIL empty_rd got udf=%b avail=%b empty=%b exp 1,0,1", m1_udf, m1_avail, m1_empty);
        end
        m1_wr = 1; m1_wdata = 8'h66; m1_rd = 1; m1_clr = 1; tick(); m1_wr = 0; m1_rd = 0; m1_clr = 0;
        vectors++;
        if ({m1_count, m1_rdata, m1_udf} !== {3'd1, 8'h66, 1'b1}) begin
            miscompares++; $display("FAIL empty_wr_rd got count=%0d r_data=%h udf=%b exp 1,66,1", m1_count, m1_rdata, m1_udf);
        end
        m1_clr = 1; m1_rd = 1; tick(); m1_clr = 0; m1_rd = 0;
        vectors++;
        if ({m1_udf, m1_empty} !== 2'b01) begin
            miscompares++; $display("FAIL stream_clr got udf=%b empty=%b exp 0,1", m1_udf, m1_empty);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            m1_write(8'(i));
            vectors++;
            if ({m1_count, m1_avail, m1_rdata} !== {3'd1, 1'b1, 8'(i)}) begin
                miscompares++; $display("FAIL wrap[%0d] got count=%0d avail=%b r_data=%h exp 1,1,%h", i, m1_count, m1_avail, m1_rdata, 8'(i));
            end
            m1_rd = 1; tick(); m1_rd = 0;
            vectors++;
            if (m1_count !== 3'd0) begin miscompares++; $display("FAIL wrap_count[%0d] got=%0d exp=0", i, m1_count); end
        end
    endtask

    task automatic test_async_reset();
        m1_write(8'hA0); m1_write(8'hA1); m1_write(8'hA2);
        #2 rst_n = 0;
        #1;
        vectors++;
        if (pack(m1_count, m1_full, m1_empty, m1_avail, m1_ovf, m1_udf, m1_rdata) !== pack(3'd0, 0, 1, 0, 0, 0, 8'h00)) begin
            miscompares++;
            $display("FAIL async_reset got count=%0d full=%b empty=%b avail=%b r_data=%h exp 0,0,1,0,00",
                     m1_count, m1_full, m1_empty, m1_avail, m1_rdata);
        end
        @(posedge clk); #1 rst_n = 1;
        m1_write(8'h5A);
        vectors++;
        if ({m1_count, m1_rdata} !== {3'd1, 8'h5A}) begin
            miscompares++; $display("FAIL post_reset got count=%0d r_data=%h exp 1,5a", m1_count, m1_rdata);
        end
        m1_rd = 1; tick(); m1_rd = 0;
    endtask

    task automatic test_random_stream();
        logic [7:0] q[$];
        logic ovf = 0, udf = 0, av, push, pop, oset, uset;
        logic [15:0] exp, act;
        m1_flush = 1; m1_clr = 1; tick(); m1_flush = 0; m1_clr = 0;
        for (int n = 0; n < 400; n++) begin
            m1_wr = ($urandom_range(0, 99) < 55);
            m1_rd = ($urandom_range(0, 99) < 50);
            m1_wdata = 8'($urandom);
            m1_flush = ($urandom_range(0, 31) == 0);
            m1_clr = ($urandom_range(0, 15) == 0);
            oset = 0; uset = 0;
            if (m1_flush) q.delete();
            else begin
                av = (q.size() > 0);
                pop = m1_rd && av;
                push = m1_wr && (q.size() < D || pop);
                oset = m1_wr && !push;
                uset = m1_rd && !av;
                if (pop) void'(q.pop_front());
                if (push) q.push_back(m1_wdata);
            end
            ovf = oset || (ovf && !m1_clr);
            udf = uset || (udf && !m1_clr);
            tick();
            av = (q.size() > 0);
            exp = pack(3'(q.size()), q.size() == D, q.size() == 0, av, ovf, udf, av ? q[0] : 8'h00);
            act = pack(m1_count, m1_full, m1_empty, m1_avail, m1_ovf, m1_udf, m1_rdata);
            vectors++;
            if (act !== exp) begin miscompares++; $display("FAIL rand_stream[%0d] got=%h exp=%h", n, act, exp); end
        end
        m1_wr = 0; m1_rd = 0; m1_flush = 0; m1_clr = 0;
    endtask

    task automatic test_random_frame();
        logic [7:0] q[$];
        logic draining = 0, ovf = 0, oset;
        logic [15:0] exp, act;
        m0_flush = 1; m0_clr = 1; tick(); m0_flush = 0; m0_clr = 0;
        for (int n = 0; n < 400; n++) begin
            m0_wr = ($urandom_range(0, 99) < 60);
            m0_rd = ($urandom_range(0, 99) < 50);
            m0_wdata = 8'($urandom);
            m0_flush = ($urandom_range(0, 31) == 0);
            m0_clr = ($urandom_range(0, 15) == 0);
            oset = 0;
            if (m0_flush) begin
                q.delete(); draining = 0;
            end else if (draining) begin
                oset = m0_wr;
                if (m0_rd) begin
                    void'(q.pop_front());
                    if (q.size() == 0) draining = 0;
                end
            end else if (m0_wr) begin
                q.push_back(m0_wdata);
                if (q.size() == D) draining = 1;
            end
            ovf = oset || (ovf && !m0_clr);
            tick();
            exp = pack(3'(q.size()), q.size() == D, q.size() == 0, draining, ovf, 1'b0, draining ? q[0] : 8'h00);
            act = pack(m0_count, m0_full, m0_empty, m0_avail, m0_ovf, m0_udf, m0_rdata);
            vectors++;
            if (act !== exp) begin miscompares++; $display("FAIL rand_frame[%0d] got=%h exp=%h", n, act, exp); end
        end
        m0_wr = 0; m0_rd = 0; m0_flush = 0; m0_clr = 0;
    endtask

    initial begin
        test_reset();
        test_frame_fill_drain();
        test_frame_misuse();
        test_flush();
        test_stream_boundaries();
        test_wrap();
        test_async_reset();
        test_random_stream();
        test_random_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
